// File: rtl/jtvigil_pcm_fetch.sv
// PCM sample fetcher: the sound CPU sets a 16-bit pointer, each advance strobe
// fetches one ROM byte. Optional ROM-wait watchdog enabled by JTVIGIL_PCM_TIMEOUT_EN.
module jtvigil_pcm_fetch #(
    parameter int TOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lo_wr,
    input  logic        hi_wr,
    input  logic        cnt_wr,
    input  logic [7:0]  din,
    output logic        rom_cs,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [7:0]  pcm_data,
    output logic        sample,
    output logic        busy,
    output logic        tout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_cnt_last;
    logic [15:0] r_ptr;
    logic [15:0] r_req_addr;
    logic [7:0]  r_pcm;
    logic        r_sample;
    logic        w_cnt_edge;
    logic [15:0] w_ptr_load;
    logic [15:0] w_ptr_inc;
    logic        w_accept;
    logic        w_timeout;

    if (TOUT_W < 2) begin : g_bad_tout_w
        $error("TOUT_W must be at least 2");
    end

    // Pointer writes land first so a same-cycle advance increments the loaded value.
    assign w_cnt_edge = cnt_wr & ~r_cnt_last;
    assign w_ptr_load = {hi_wr ? din : r_ptr[15:8], lo_wr ? din : r_ptr[7:0]};
    assign w_ptr_inc  = w_ptr_load + 16'd1;
    assign w_accept   = (r_state == ST_WAIT) && rom_ok && !w_cnt_edge;

`ifdef JTVIGIL_PCM_TIMEOUT_EN
    logic [TOUT_W-1:0] r_tcnt;
    logic [TOUT_W-1:0] w_tcnt_next;
    logic              r_tout;

    assign w_tcnt_next = r_tcnt + 1'b1;
    assign w_timeout   = (r_state == ST_WAIT) && !rom_ok && !w_cnt_edge
                         && (w_tcnt_next == '1);
    assign tout        = r_tout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_tout <= 1'b0;
        end else begin
            if (w_cnt_edge) begin
                r_tcnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tcnt <= w_tcnt_next;
            end
            if (w_timeout) begin
                r_tout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign tout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An advance edge always restarts the fetch, abandoning any one in flight.
    always_comb begin
        w_state_next = r_state;
        if (w_cnt_edge) begin
            w_state_next = ST_GUARD;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_IDLE;
                ST_GUARD: w_state_next = ST_WAIT;
                ST_WAIT: begin
                    if (w_accept || w_timeout) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rom_cs = 1'b0;
        if (r_state != ST_IDLE) begin
            rom_cs = 1'b1;
        end
        busy = rom_cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_last <= 1'b0;
            r_ptr      <= 16'h0000;
            r_req_addr <= 16'h0000;
        end else begin
            r_cnt_last <= cnt_wr;
            if (w_cnt_edge) begin
                r_ptr      <= w_ptr_inc;
                r_req_addr <= w_ptr_inc;
            end else begin
                r_ptr <= w_ptr_load;
            end
        end
    end

    // A watchdog expiry repeats the previous sample rather than emitting garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm    <= 8'h80;
            r_sample <= 1'b0;
        end else begin
            r_sample <= w_accept | w_timeout;
            if (w_accept) begin
                r_pcm <= rom_data;
            end
        end
    end

    assign rom_addr = r_req_addr;
    assign pcm_data = r_pcm;
    assign sample   = r_sample;

endmodule

// File: tb/tb_jtvigil_pcm_fetch.sv
// Scoreboard bench for jtvigil_pcm_fetch; expected samples and state probes are
// queued by the stimulus and compared by a single negedge monitor.
module tb_jtvigil_pcm_fetch;

   localparam int K_ADDR   = 0;
   localparam int K_CS     = 1;
   localparam int K_BUSY   = 2;
   localparam int K_PCM    = 3;
   localparam int K_SAMPLE = 4;
   localparam int K_TOUT   = 5;
   localparam int K_EMPTY  = 6;

   logic        clk;
   logic        rst_n;
   logic        loWr;
   logic        hiWr;
   logic        cntWr;
   logic [7:0]  din;
   logic        romCs;
   logic [15:0] romAddr;
   logic [7:0]  romData;
   logic        romOk;
   logic [7:0]  pcmData;
   logic        sampleOut;
   logic        busyOut;
   logic        toutOut;

   int checks = 0;
   int failures = 0;

   logic [15:0] sbAddr[$];
   logic [7:0]  sbData[$];
   int          probeKind[$];
   logic [15:0] probeExp[$];
   string       probeName[$];

   jtvigil_pcm_fetch #(.TOUT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lo_wr    (loWr),
      .hi_wr    (hiWr),
      .cnt_wr   (cntWr),
      .din      (din),
      .rom_cs   (romCs),
      .rom_addr (romAddr),
      .rom_data (romData),
      .rom_ok   (romOk),
      .pcm_data (pcmData),
      .sample   (sampleOut),
      .busy     (busyOut),
      .tout     (toutOut)
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every falling edge, score any sample pulse and evaluate queued probes.
   always @(negedge clk) begin
      logic [15:0] act;
      logic [15:0] ea;
      logic [7:0]  ed;
      if (sampleOut) begin
         if (sbAddr.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_sample: got pcm=%02h addr=%04h, required no sample", pcmData, romAddr);
         end else begin
            ea = sbAddr.pop_front();
            ed = sbData.pop_front();
            checks++;
            if (pcmData !== ed) begin
               failures++;
               $display("[TB] FAIL sample_data: got %02h, required %02h", pcmData, ed);
            end
            checks++;
            if (romAddr !== ea) begin
               failures++;
               $display("[TB] FAIL sample_addr: got %04h, required %04h", romAddr, ea);
            end
         end
      end
      while (probeKind.size() > 0) begin
         int    k;
         string n;
         logic [15:0] e;
         k = probeKind.pop_front();
         e = probeExp.pop_front();
         n = probeName.pop_front();
         case (k)
            K_ADDR:   act = romAddr;
            K_CS:     act = {15'd0, romCs};
            K_BUSY:   act = {15'd0, busyOut};
            K_PCM:    act = {8'd0, pcmData};
            K_SAMPLE: act = {15'd0, sampleOut};
            K_TOUT:   act = {15'd0, toutOut};
            default:  act = 16'(sbAddr.size());
         endcase
         checks++;
         if (act !== e) begin
            failures++;
            $display("[TB] FAIL %s: got %04h, required %04h", n, act, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic lo, input logic hi, input logic cnt,
                                input logic [7:0] d, input logic ok, input logic [7:0] rd);
      loWr    = lo;
      hiWr    = hi;
      cntWr   = cnt;
      din     = d;
      romOk   = ok;
      romData = rd;
   endtask

   task automatic checkOutput(input int kind, input logic [15:0] exp, input string name);
      probeKind.push_back(kind);
      probeExp.push_back(exp);
      probeName.push_back(name);
   endtask

   task automatic expectSample(input logic [15:0] a, input logic [7:0] d);
      sbAddr.push_back(a);
      sbData.push_back(d);
   endtask

   // Directed stimulus sequence.
   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      tick();
      checkOutput(K_ADDR, 16'h0000, "reset_addr");
      checkOutput(K_CS, 16'h0, "reset_cs");
      checkOutput(K_BUSY, 16'h0, "reset_busy");
      checkOutput(K_PCM, 16'h0080, "reset_pcm");
      checkOutput(K_SAMPLE, 16'h0, "reset_sample");
      checkOutput(K_TOUT, 16'h0, "reset_tout");
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] first fetch after reset, pointer write while busy");
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_ADDR, 16'h0001, "first_addr");
      checkOutput(K_CS, 16'h1, "first_cs");
      applyStimulus(1, 0, 0, 8'hAA, 0, 8'h00);
      tick();
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      checkOutput(K_ADDR, 16'h0001, "addr_held_on_ptr_write");
      checkOutput(K_BUSY, 16'h1, "busy_waiting");
      tick();
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h55);
      expectSample(16'h0001, 8'h55);
      tick();
      checkOutput(K_SAMPLE, 16'h1, "first_sample");
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_SAMPLE, 16'h0, "first_sample_one_clk");
      checkOutput(K_CS, 16'h0, "first_idle_cs");

      $display("[TB] pointer 0x1234 then advance");
      applyStimulus(1, 0, 0, 8'h34, 1, 8'h9A);
      tick();
      applyStimulus(0, 1, 0, 8'h12, 1, 8'h9A);
      tick();
      applyStimulus(0, 0, 1, 8'h00, 1, 8'h9A);
      expectSample(16'h1235, 8'h9A);
      tick();
      checkOutput(K_ADDR, 16'h1235, "addr_1235");
      checkOutput(K_SAMPLE, 16'h0, "lat_e0");
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h9A);
      tick();
      checkOutput(K_SAMPLE, 16'h0, "lat_e1");
      tick();
      checkOutput(K_SAMPLE, 16'h1, "lat_e2");
      tick();
      checkOutput(K_PCM, 16'h009A, "pcm_hold_9a");
      checkOutput(K_SAMPLE, 16'h0, "lat_after");

      $display("[TB] wrap 0xFFFF");
      applyStimulus(1, 1, 0, 8'hFF, 0, 8'h00);
      tick();
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_ADDR, 16'h0000, "wrap_addr");
      checkOutput(K_CS, 16'h1, "wrap_cs");
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h22);
      expectSample(16'h0000, 8'h22);
      tick();
      tick();
      checkOutput(K_SAMPLE, 16'h1, "wrap_sample");
      tick();

      $display("[TB] same-cycle load and advance, stale rom_ok held high");
      applyStimulus(1, 0, 1, 8'h40, 1, 8'h33);
      expectSample(16'h0041, 8'h33);
      tick();
      checkOutput(K_ADDR, 16'h0041, "load_then_inc_addr");
      checkOutput(K_SAMPLE, 16'h0, "guard_e0_no_sample");
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h33);
      tick();
      checkOutput(K_SAMPLE, 16'h0, "guard_ignores_ok");
      tick();
      checkOutput(K_SAMPLE, 16'h1, "wait_accepts_ok");
      tick();

      $display("[TB] second advance two clocks after first");
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_ADDR, 16'h0043, "double_edge_addr");
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      tick();
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h44);
      expectSample(16'h0043, 8'h44);
      tick();
      tick();
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);

      $display("[TB] advance held high ten clocks");
      applyStimulus(0, 0, 1, 8'h00, 1, 8'h66);
      expectSample(16'h0044, 8'h66);
      repeat (10) tick();
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h66);
      tick();
      checkOutput(K_ADDR, 16'h0044, "held_cnt_addr");
      checkOutput(K_CS, 16'h0, "held_cnt_idle");

      $display("[TB] advance while waiting abandons fetch");
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_ADDR, 16'h0045, "single_advance_addr");
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      tick();
      applyStimulus(0, 0, 1, 8'h00, 1, 8'h77);
      expectSample(16'h0046, 8'h77);
      tick();
      checkOutput(K_ADDR, 16'h0046, "abandon_addr");
      checkOutput(K_SAMPLE, 16'h0, "abandon_no_sample");
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h77);
      tick();
      checkOutput(K_SAMPLE, 16'h0, "abandon_guard");
      tick();
      checkOutput(K_SAMPLE, 16'h1, "abandon_refetch_sample");
      tick();

      $display("[TB] reset mid-fetch");
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();
      rst_n = 1'b0;
      checkOutput(K_ADDR, 16'h0000, "midreset_addr");
      checkOutput(K_CS, 16'h0, "midreset_cs");
      checkOutput(K_BUSY, 16'h0, "midreset_busy");
      checkOutput(K_PCM, 16'h0080, "midreset_pcm");
      tick();
      applyStimulus(0, 0, 0, 8'h00, 1, 8'h99);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      checkOutput(K_SAMPLE, 16'h0, "postreset_no_sample");
      checkOutput(K_EMPTY, 16'h0, "postreset_sb_empty");
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
      tick();

      $display("[TB] rom_ok stuck low");
      applyStimulus(0, 0, 1, 8'h00, 0, 8'h00);
      tick();
      checkOutput(K_ADDR, 16'h0001, "stuck_addr");
      applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
`ifdef JTVIGIL_PCM_TIMEOUT_EN
      expectSample(16'h0001, 8'h80);
      repeat (255) tick();
      checkOutput(K_SAMPLE, 16'h0, "tout_pre_sample");
      checkOutput(K_BUSY, 16'h1, "tout_pre_busy");
      checkOutput(K_TOUT, 16'h0, "tout_pre_flag");
      tick();
      checkOutput(K_SAMPLE, 16'h1, "tout_sample");
      checkOutput(K_TOUT, 16'h1, "tout_flag");
      checkOutput(K_BUSY, 16'h0, "tout_busy");
      checkOutput(K_PCM, 16'h0080, "tout_pcm");
      tick();
      checkOutput(K_TOUT, 16'h1, "tout_sticky");
`else
      repeat (300) tick();
      checkOutput(K_BUSY, 16'h1, "stuck_busy");
      checkOutput(K_TOUT, 16'h0, "stuck_tout");
      checkOutput(K_SAMPLE, 16'h0, "stuck_no_sample");
`endif
      tick();
      checkOutput(K_EMPTY, 16'h0, "final_sb_empty");
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jtvigil_pcm_fetch.md
JTVIGIL_PCM_FETCH -- requirements
Module: jtvigil_pcm_fetch

Interface
REQ-001 Parameter TOUT_W, default 8, width of the ROM-wait watchdog counter.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 lo_wr  in  1  sound-CPU write strobe for the pointer low byte; level, may last several clk.
REQ-005 hi_wr  in  1  sound-CPU write strobe for the pointer high byte; level.
REQ-006 cnt_wr  in  1  sound-CPU "advance" strobe; level, acted on at rising edge only.
REQ-007 din  in  8  sound-CPU data bus.
REQ-008 rom_cs  out  1  PCM ROM request to the SDRAM arbiter.
REQ-009 rom_addr  out  16  PCM ROM byte address.
REQ-010 rom_data  in  8  PCM ROM data; valid only while rom_ok=1 for the current rom_addr.
REQ-011 rom_ok  in  1  ROM data valid.
REQ-012 pcm_data  out  8  last accepted sample, unsigned, offset 0x80.
REQ-013 sample  out  1  one-clk pulse when pcm_data updates.
REQ-014 busy  out  1  high while a fetch is outstanding.
REQ-015 tout  out  1  sticky watchdog flag (see Configuration).

Function
REQ-016 Pointer ptr[15:0]: lo_wr loads ptr[7:0]<=din; hi_wr loads ptr[15:8]<=din; every clk the strobe is high, no fetch started.
REQ-017 Rising edge of cnt_wr (cnt_wr=1, previous-cycle cnt_wr=0): ptr<=ptr+1 mod 2^16 (0xFFFF wraps to 0x0000), and a fetch starts for the incremented value.
REQ-018 Same-cycle lo_wr/hi_wr and cnt_wr edge: the load takes effect first, then the increment applies to the loaded value.
REQ-019 FSM states IDLE, GUARD, WAIT. IDLE->GUARD on cnt_wr edge; GUARD->WAIT after exactly one clk; WAIT->IDLE on rom_ok=1.
REQ-020 On fetch start, req_addr<=new ptr; rom_addr=req_addr at all times; later pointer writes do not alter rom_addr.
REQ-021 rom_cs=1 in GUARD and WAIT, 0 in IDLE; busy equals rom_cs.
REQ-022 GUARD ignores rom_ok so that stale ok from the previous address is never accepted.
REQ-023 In WAIT with rom_ok=1: pcm_data<=rom_data, sample=1 on the next clk for one clk only.
REQ-024 Minimum latency cnt_wr edge -> sample pulse: 3 clk (edge capture, GUARD, WAIT with rom_ok already high).
REQ-025 cnt_wr edge while busy: current fetch abandoned without sample, ptr increments, req_addr reloads, FSM re-enters GUARD.
REQ-026 pcm_data holds its value between samples; never changes without a sample pulse.

Reset
REQ-027 rst_n=0 forces asynchronously: ptr=0, req_addr=0, pcm_data=0x80, sample=0, rom_cs=0, busy=0, tout=0, FSM=IDLE, edge register=0, watchdog=0.
REQ-028 Reset mid-fetch discards the outstanding fetch; no sample pulse follows release.
REQ-029 First cnt_wr edge after release fetches address 0x0001.

Configuration
REQ-030 Macro JTVIGIL_PCM_TIMEOUT_EN defined: TOUT_W-bit counter clears on GUARD entry, counts each WAIT clk; on reaching all ones FSM goes IDLE, pcm_data unchanged, sample=1 (repeat previous sample), tout<=1 until reset.
REQ-031 Macro undefined: no counter, WAIT persists until rom_ok, tout tied to 0.

Verification
REQ-032 lo_wr din=0x34, hi_wr din=0x12, cnt_wr edge, rom_ok=1 data 0x9A -> rom_addr=0x1235, sample pulse 3 clk after edge, pcm_data=0x9A.
REQ-033 ptr=0xFFFF, cnt_wr edge -> rom_addr=0x0000, rom_cs=1.
REQ-034 rom_ok held high from previous fetch, new cnt_wr edge with rom_data 0x11 -> no sample during GUARD; sample in WAIT gives 0x11 from new address.
REQ-035 Second cnt_wr edge 2 clk after first, rom_ok delayed -> exactly one sample pulse, rom_addr = first+1.
REQ-036 cnt_wr held high 10 clk -> ptr advances exactly once.
REQ-037 With JTVIGIL_PCM_TIMEOUT_EN, TOUT_W=8, rom_ok stuck 0 -> after 255 WAIT clk sample pulse, pcm_data unchanged, tout=1, busy=0.
